// File: rtl/if_inst_queue.sv
// Instruction fetch queue: buffers {pc, inst} beats from the instruction SRAM for decode.
// Optional same-cycle bypass when empty is enabled by defining IFQ_BYPASS_EN.
module if_inst_queue #(
    parameter int          DEPTH        = 4,
    parameter int          IN_FLIGHT    = 1,
    parameter logic [31:0] RESET_PC_TAG = 32'h1bfffffc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_inst,
    output logic        fetch_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready,
    input  logic        flush,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][31:0] r_pc;
    logic [DEPTH-1:0][31:0] r_inst;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_beat;
    logic          w_pop;
    logic          w_push;
    logic          w_byp_take;
    logic [CW-1:0] w_free;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_beat  = fetch_valid & ~flush;
    // Array pop only: a bypassed beat never occupied a slot.
    assign w_pop   = ~w_empty & id_ready & ~flush;

`ifdef IFQ_BYPASS_EN
    assign w_byp_take = w_empty & w_beat & id_ready;
    always_comb begin
        id_valid = ~w_empty | w_beat;
        id_pc    = RESET_PC_TAG;
        id_inst  = 32'h0;
        if (!w_empty) begin
            id_pc   = r_pc[r_rd_ptr];
            id_inst = r_inst[r_rd_ptr];
        end else if (w_beat) begin
            id_pc   = fetch_pc;
            id_inst = fetch_inst;
        end
    end
`else
    assign w_byp_take = 1'b0;
    always_comb begin
        id_valid = ~w_empty;
        id_pc    = RESET_PC_TAG;
        id_inst  = 32'h0;
        if (!w_empty) begin
            id_pc   = r_pc[r_rd_ptr];
            id_inst = r_inst[r_rd_ptr];
        end
    end
`endif

    // Full is writable only when the head leaves in the same cycle.
    assign w_push = w_beat & (~w_full | w_pop) & ~w_byp_take;

    // count never exceeds DEPTH, so the subtraction cannot wrap.
    assign w_free      = CW'(DEPTH) - r_count;
    assign fetch_ready = {{(32-CW){1'b0}}, w_free} > 32'(IN_FLIGHT);
    assign ovf_err     = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]   <= fetch_pc;
                r_inst[r_wr_ptr] <= fetch_inst;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_beat && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end
endmodule
